bcp_implication_queue: RTL

- Sits directly downstream of the BCP clause checker and closes the propagation loop.
- Buffers the checker's unit implications in a small FIFO and applies them to the solver's variable state (free/assignment).
- Detects conflicts, then re-launches the checker with en until no new assignments result.
- Owns the free/assignment registers that feed the checker. Decisions and backtrack reloads come from the solver controller.

---
 rtl/bcp_implication_queue_if.sv | 52 +++++
 rtl/bcp_implication_queue.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/bcp_implication_queue_if.sv
//------------------------------------------------------------------------------
// Module   : bcp_implication_queue_if
// Purpose  : Bundles the checker, controller and variable-state signals of the
//            BCP implication queue.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

interface bcp_implication_queue_if #(
    parameter int NUM_VARS = 4,
    parameter int VAR_W    = 2
);
    logic                unit_exist;
    logic [VAR_W-1:0]    encoded_implication;
    logic                impl_value;
    logic                bcp_done;
    logic                dec_valid;
    logic [VAR_W-1:0]    dec_var;
    logic                dec_value;
    logic                load_valid;
    logic [NUM_VARS-1:0] load_free;
    logic [NUM_VARS-1:0] load_assignment;
    logic                en;
    logic [NUM_VARS-1:0] free;
    logic [NUM_VARS-1:0] assignment;
    logic                conflict;
    logic [VAR_W-1:0]    conflict_var;
    logic                ovf;
    logic                dec_err;
    logic                prop_done;
    logic                idle;

    // Checker/controller side
    modport master (
        output unit_exist, encoded_implication, impl_value, bcp_done,
               dec_valid, dec_var, dec_value,
               load_valid, load_free, load_assignment,
        input  en, free, assignment, conflict, conflict_var,
               ovf, dec_err, prop_done, idle
    );

    // Queue side
    modport slave (
        input  unit_exist, encoded_implication, impl_value, bcp_done,
               dec_valid, dec_var, dec_value,
               load_valid, load_free, load_assignment,
        output en, free, assignment, conflict, conflict_var,
               ovf, dec_err, prop_done, idle
    );
endinterface

`default_nettype wire

// File: rtl/bcp_implication_queue.sv
//------------------------------------------------------------------------------
// Module   : bcp_implication_queue
// Purpose  : Buffers unit implications, applies them to free/assignment and
//            re-launches the clause checker until fixpoint or conflict.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module bcp_implication_queue #(
    parameter int NUM_VARS = 4,
    parameter int VAR_W    = 2,
    parameter int DEPTH    = 4
) (
    input  wire logic               clk,
    input  wire logic               rst,
    bcp_implication_queue_if.slave  bus
);
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = VAR_W + 1;

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_BCP = 2'd1;
    localparam logic [1:0] APPLY    = 2'd2;
    localparam logic [1:0] CONFLICT = 2'd3;

    logic [1:0]          state_q, state_d;
    logic [NUM_VARS-1:0] free_q, free_d, assign_q, assign_d;
    logic                en_q, en_d, conflict_q, conflict_d, ovf_q, ovf_d;
    logic [VAR_W-1:0]    cvar_q, cvar_d;
    logic                dec_err_q, dec_err_d, prop_done_q, prop_done_d;
    logic                progress_q, progress_d;
    logic [PTR_W:0]      wr_q, wr_d, rd_q, rd_d;
    logic [ENTRY_W-1:0]  fifo_q [DEPTH];

    function automatic logic in_range(input logic [VAR_W-1:0] idx);
        return int'(idx) < NUM_VARS;
    endfunction

    logic               full, empty;
    logic [ENTRY_W-1:0] head;
    logic [VAR_W-1:0]   head_var;
    logic               head_val;
    logic               dec_go, dec_bad;
    logic               push_ok, push_ovf, wait_done, wait_has;
    logic               app_new, app_cfl, app_last, progress_nxt;
    logic [PTR_W:0]     rd_inc;

    // Extra pointer bit separates full from empty when the low bits match
    assign full  = (wr_q[PTR_W] != rd_q[PTR_W]) && (wr_q[PTR_W-1:0] == rd_q[PTR_W-1:0]);
    assign empty = (wr_q == rd_q);
    assign head     = fifo_q[rd_q[PTR_W-1:0]];
    assign head_var = head[ENTRY_W-1:1];
    assign head_val = head[0];
    assign rd_inc   = rd_q + 1'b1;

    assign dec_go   = (state_q == IDLE) && bus.dec_valid && in_range(bus.dec_var) &&  free_q[bus.dec_var];
    assign dec_bad  = (state_q == IDLE) && bus.dec_valid && in_range(bus.dec_var) && !free_q[bus.dec_var];
    assign push_ok  = (state_q == WAIT_BCP) && bus.unit_exist && !full;
    assign push_ovf = (state_q == WAIT_BCP) && bus.unit_exist &&  full;
    assign wait_done = (state_q == WAIT_BCP) && bus.bcp_done && !push_ovf;
    assign wait_has  = push_ok || !empty;
    assign app_new  = (state_q == APPLY) && in_range(head_var) && free_q[head_var];
    assign app_cfl  = (state_q == APPLY) && in_range(head_var) && !free_q[head_var]
                      && (assign_q[head_var] != head_val);
    assign app_last = (state_q == APPLY) && !app_cfl && (rd_inc == wr_q);
    assign progress_nxt = progress_q || app_new;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            free_q      <= '1;
            assign_q    <= '0;
            en_q        <= 1'b0;
            conflict_q  <= 1'b0;
            ovf_q       <= 1'b0;
            cvar_q      <= '0;
            dec_err_q   <= 1'b0;
            prop_done_q <= 1'b0;
            progress_q  <= 1'b0;
            wr_q        <= '0;
            rd_q        <= '0;
            for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
        end else begin
            state_q     <= state_d;
            free_q      <= free_d;
            assign_q    <= assign_d;
            en_q        <= en_d;
            conflict_q  <= conflict_d;
            ovf_q       <= ovf_d;
            cvar_q      <= cvar_d;
            dec_err_q   <= dec_err_d;
            prop_done_q <= prop_done_d;
            progress_q  <= progress_d;
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            if (push_ok && !bus.load_valid)
                fifo_q[wr_q[PTR_W-1:0]] <= {bus.encoded_implication, bus.impl_value};
        end
    end

    always_comb begin : p_next_state
        state_d = state_q;
        unique case (state_q)
            IDLE:     if (dec_go) state_d = WAIT_BCP;
            WAIT_BCP: begin
                if (push_ovf)       state_d = CONFLICT;
                else if (wait_done) state_d = wait_has ? APPLY : IDLE;
            end
            APPLY: begin
                if (app_cfl)       state_d = CONFLICT;
                else if (app_last) state_d = progress_nxt ? WAIT_BCP : IDLE;
            end
            default:  state_d = state_q;
        endcase
        if (bus.load_valid) state_d = IDLE;
    end

    always_comb begin : p_outputs
        free_d      = free_q;
        assign_d    = assign_q;
        en_d        = 1'b0;
        conflict_d  = conflict_q;
        ovf_d       = ovf_q;
        cvar_d      = cvar_q;
        dec_err_d   = dec_bad;
        prop_done_d = 1'b0;
        progress_d  = progress_q;
        wr_d        = push_ok ? wr_q + 1'b1 : wr_q;
        rd_d        = rd_q;

        if (dec_go) begin
            free_d[bus.dec_var]   = 1'b0;
            assign_d[bus.dec_var] = bus.dec_value;
            en_d                  = 1'b1;
            progress_d            = 1'b0;
        end
        if (push_ovf) begin
            ovf_d      = 1'b1;
            conflict_d = 1'b1;
        end
        if (wait_done && !wait_has) prop_done_d = 1'b1;

        if (state_q == APPLY) begin
            rd_d = rd_inc;
            if (app_new) begin
                free_d[head_var]   = 1'b0;
                assign_d[head_var] = head_val;
            end
            // Drop whatever is still queued once a conflict is found
            if (app_cfl) begin
                conflict_d = 1'b1;
                cvar_d     = head_var;
                rd_d       = wr_q;
            end else begin
                progress_d = progress_nxt;
            end
            if (app_last) begin
                en_d        = progress_nxt;
                prop_done_d = !progress_nxt;
                progress_d  = 1'b0;
            end
        end

        if (bus.load_valid) begin
            free_d      = bus.load_free;
            assign_d    = bus.load_assignment;
            en_d        = 1'b0;
            conflict_d  = 1'b0;
            ovf_d       = 1'b0;
            cvar_d      = '0;
            dec_err_d   = 1'b0;
            prop_done_d = 1'b0;
            progress_d  = 1'b0;
            wr_d        = '0;
            rd_d        = '0;
        end
    end

    assign bus.en           = en_q;
    assign bus.free         = free_q;
    assign bus.assignment   = assign_q;
    assign bus.conflict     = conflict_q;
    assign bus.conflict_var = cvar_q;
    assign bus.ovf          = ovf_q;
    assign bus.dec_err      = dec_err_q;
    assign bus.prop_done    = prop_done_q;
    assign bus.idle         = (state_q == IDLE);
endmodule

`default_nettype wire
